oak_sequencer: RTL and testbench
================================

Name: oak_sequencer

Overview:
- Multi-cycle control unit for the oak8 stack core; sequences the combinational instruction evaluator (`program_ev`).
- Fetches opcodes from a synchronous program memory and owns PC, SP and a 16x8 stack register file.
- Feeds the evaluator, then commits its results: PC, SP, stack write, program-memory write, sleep, stop.
- A host preloads the stack through a valid/ready push port and starts execution with a pulse.

Parameters:
- SLEEP_CYCLES, 16, cycles spent in SLEEP per sleep opcode (0xA); must be >= 1.
- START_PC, 6'd0, PC value loaded at reset and on every start.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or HALT.
- push_valid  in  1  host stack-push request.
- push_data  in  8  byte to push.
- push_ready  out  1  high only in IDLE.
- pmem_raddr  out  6  program memory read address; rdata valid the cycle after.
- pmem_rdata  in  8  program memory read data.
- pmem_we  out  1  program memory write strobe, one cycle.
- pmem_waddr  out  6  write address.
- pmem_wdata  out  8  write data.
- ev_opcode  out  4  to evaluator.
- ev_pc  out  6  to evaluator.
- ev_sp  out  4  to evaluator.
- ev_top  out  8  to evaluator.
- ev_btop  out  8  to evaluator.
- ev_pmem_in  out  8  to evaluator.
- ev_pc_plus  in  6  from evaluator.
- ev_sp_min  in  4  from evaluator.
- ev_sp_w_cnt  in  8  from evaluator.
- ev_new_top  in  8  from evaluator.
- ev_pmem_we  in  1  from evaluator.
- ev_pmem_w_addr  in  6  from evaluator.
- ev_pmem_out  in  8  from evaluator.
- ev_sleep  in  1  from evaluator.
- ev_stop  in  1  from evaluator.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async): state IDLE, pc=START_PC, sp=0, all 16 stack entries 0, instr=0, mdata=0, sleep counter 0, pmem_we=0, pmem_raddr=0, pmem_waddr=0, pmem_wdata=0.
- Stack view: ev_top=stack[sp], ev_btop=stack[sp-1 mod 16], ev_sp=sp, ev_pc=pc, ev_opcode=instr[3:0], ev_pmem_in=mdata.
- States: IDLE, FETCH, DECODE, MEMRD, MEMWAIT, EXEC, SLEEP, HALT.
- IDLE
  - push_ready=1; on push_valid: sp<=sp+1, stack[sp+1]<=push_data, in the same cycle.
  - start: pc<=START_PC, go to FETCH. start wins over a simultaneous push; the push is not accepted.
- FETCH: pmem_raddr=pc -> DECODE.
- DECODE: instr<=pmem_rdata. If pmem_rdata[3:0]==8 -> MEMRD, else -> EXEC.
- MEMRD: pmem_raddr=stack[sp][5:0] -> MEMWAIT.
- MEMWAIT: mdata<=pmem_rdata -> EXEC.
- EXEC (single commit cycle):
  - pc<=ev_pc_plus, sp<=ev_sp_min.
  - If ev_sp_w_cnt!=0: stack[ev_sp_min]<=ev_new_top.
  - If ev_pmem_we: register pmem_we=1, pmem_waddr=ev_pmem_w_addr, pmem_wdata=ev_pmem_out. Visible the following cycle for exactly one cycle.
  - Next state: ev_stop -> HALT; ev_sleep -> SLEEP with counter<=SLEEP_CYCLES-1; else FETCH.
  - Undefined opcodes (0xB-0xE) only advance pc.
- SLEEP: counter decrements each cycle; at 0 -> FETCH.
- HALT: pc/sp/stack frozen. start -> FETCH with pc<=START_PC; sp and stack are preserved.
- Latency
  - Normal instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Opcode 8: 5 cycles.
  - Sleep: 3+SLEEP_CYCLES.
- Width and wrap rules
  - pc wraps 63->0.
  - sp and stack indices are mod 16: push at sp=15 writes stack[0]; pop at sp=0 gives 15. No error flag.
  - ev_pc_plus is taken as 6 bits.
- start while busy: ignored. push_valid while not IDLE: ignored (ready=0).
- Reset mid-instruction: any pending pmem_we is dropped; no partial commit.

Decomposition:
- Shared package oak_pkg:
  - state enum encoding (3 bits).
  - opcode constants: OP_ADD=0 through OP_MOV=9, OP_SLEEP=A, OP_STOP=F.
  - widths: PC_W=6, SP_W=4, DW=8.
- One natural sub-module: oak_stack_rf.
  - 16x8 async-reset register file.
  - Two combinational read ports (sp, sp-1) plus a mem-addr read.
  - One write port.
- The sequencer FSM remains in oak_sequencer; it instantiates program_ev externally (ports above) so it can be bench-driven alone.

Test Plan:
- Push 3, push 5, program[0]=0x00 (ADD), program[1]=0x0F, start -> after EXEC sp=1, stack[1]=8, then halted=1, pc=2.
- Stack {top=0x10, btop=0xAA}, opcode 7 -> one-cycle pmem_we with waddr=0x10, wdata=0xAA, and sp decremented by 2 mod 16.
- program[0x20]=0x5C; stack top=0x20; opcode 8 -> 5-cycle instruction, stack[sp]=0x5C, sp unchanged.
- Opcode A with SLEEP_CYCLES=16 -> busy stays high, next FETCH exactly 19 cycles after the prior FETCH; pc=+1.
- 17 pushes from reset -> sp=1 and stack[1] overwritten with 17th byte. Start and push in the same IDLE cycle -> push not accepted, FETCH entered.
- Assert rst_n low during MEMWAIT and during the cycle after an opcode-7 EXEC -> all state at reset values, pmem_we never pulses.

Source files
------------

// File: rtl/oak_pkg.sv
// Shared widths, FSM state encoding and opcode map for the oak8 sequencer.
package oak_pkg;

  localparam int PC_W  = 6;
  localparam int SP_W  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_MEMRD   = 3'd3;
  localparam logic [2:0] ST_MEMWAIT = 3'd4;
  localparam logic [2:0] ST_EXEC    = 3'd5;
  localparam logic [2:0] ST_SLEEP   = 3'd6;
  localparam logic [2:0] ST_HALT    = 3'd7;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_DUP   = 4'h5;
  localparam logic [3:0] OP_DROP  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_MOV   = 4'h9;
  localparam logic [3:0] OP_SLEEP = 4'hA;
  localparam logic [3:0] OP_STOP  = 4'hF;

endpackage

// File: rtl/oak_stack_rf.sv
// 16x8 stack register file: reads at sp and sp-1 (mod 16), one write port.
module oak_stack_rf
  import oak_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SP_W-1:0] i_sp,
  output logic [DW-1:0]   o_top,
  output logic [DW-1:0]   o_btop,
  output logic [PC_W-1:0] o_maddr,
  input  logic            i_we,
  input  logic [SP_W-1:0] i_waddr,
  input  logic [DW-1:0]   i_wdata
);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [SP_W-1:0] w_sp_m1;

  assign w_sp_m1 = i_sp - 1'b1;
  assign o_top   = r_mem[i_sp];
  assign o_btop  = r_mem[w_sp_m1];
  assign o_maddr = r_mem[i_sp][PC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/oak_sequencer.sv
// oak8 multi-cycle control unit: fetches opcodes, feeds the external evaluator
// and commits its results to pc, sp, the stack and program memory.
//
// state   | meaning
// IDLE    | host may push onto the stack; waits for start
// FETCH   | program memory addressed with pc
// DECODE  | opcode captured; loads take the memory detour
// MEMRD   | program memory addressed with stack top
// MEMWAIT | memory operand captured
// EXEC    | single commit cycle for the evaluator results
// SLEEP   | counts down before the next fetch
// HALT    | frozen until the next start
module oak_sequencer
  import oak_pkg::*;
#(
  parameter int unsigned     SLEEP_CYCLES = 16,
  parameter logic [PC_W-1:0] START_PC     = 6'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            push_valid,
  input  logic [DW-1:0]   push_data,
  output logic            push_ready,
  output logic [PC_W-1:0] pmem_raddr,
  input  logic [DW-1:0]   pmem_rdata,
  output logic            pmem_we,
  output logic [PC_W-1:0] pmem_waddr,
  output logic [DW-1:0]   pmem_wdata,
  output logic [3:0]      ev_opcode,
  output logic [PC_W-1:0] ev_pc,
  output logic [SP_W-1:0] ev_sp,
  output logic [DW-1:0]   ev_top,
  output logic [DW-1:0]   ev_btop,
  output logic [DW-1:0]   ev_pmem_in,
  input  logic [PC_W-1:0] ev_pc_plus,
  input  logic [SP_W-1:0] ev_sp_min,
  input  logic [DW-1:0]   ev_sp_w_cnt,
  input  logic [DW-1:0]   ev_new_top,
  input  logic            ev_pmem_we,
  input  logic [PC_W-1:0] ev_pmem_w_addr,
  input  logic [DW-1:0]   ev_pmem_out,
  input  logic            ev_sleep,
  input  logic            ev_stop,
  output logic            busy,
  output logic            halted
);

  localparam int               CNT_W      = (SLEEP_CYCLES > 1) ? $clog2(SLEEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLEEP_LOAD = CNT_W'(SLEEP_CYCLES - 1);

  logic [2:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [SP_W-1:0]  r_sp;
  logic [3:0]       r_instr;
  logic [DW-1:0]    r_mdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pmem_we;
  logic [PC_W-1:0]  r_pmem_waddr;
  logic [DW-1:0]    r_pmem_wdata;

  logic             w_push;
  logic             w_rf_we;
  logic [SP_W-1:0]  w_rf_waddr;
  logic [DW-1:0]    w_rf_wdata;
  logic [DW-1:0]    w_top;
  logic [DW-1:0]    w_btop;
  logic [PC_W-1:0]  w_maddr;

  // start takes priority, so a push in the same cycle is dropped
  assign w_push = (r_state == ST_IDLE) && push_valid && !start;

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = r_sp + 1'b1;
    w_rf_wdata = push_data;
    if (w_push) begin
      w_rf_we = 1'b1;
    end else if ((r_state == ST_EXEC) && (ev_sp_w_cnt != '0)) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = ev_sp_min;
      w_rf_wdata = ev_new_top;
    end
  end

  oak_stack_rf u_stack_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sp    (r_sp),
    .o_top   (w_top),
    .o_btop  (w_btop),
    .o_maddr (w_maddr),
    .i_we    (w_rf_we),
    .i_waddr (w_rf_waddr),
    .i_wdata (w_rf_wdata)
  );

  always_comb begin
    pmem_raddr = '0;
    if (r_state == ST_FETCH)      pmem_raddr = r_pc;
    else if (r_state == ST_MEMRD) pmem_raddr = w_maddr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= START_PC;
      r_sp         <= '0;
      r_instr      <= '0;
      r_mdata      <= '0;
      r_cnt        <= '0;
      r_pmem_we    <= 1'b0;
      r_pmem_waddr <= '0;
      r_pmem_wdata <= '0;
    end else begin
      r_pmem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc    <= START_PC;
            r_state <= ST_FETCH;
          end else if (push_valid) begin
            r_sp <= r_sp + 1'b1;
          end
        end
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_instr <= pmem_rdata[3:0];
          r_state <= (pmem_rdata[3:0] == OP_LOAD) ? ST_MEMRD : ST_EXEC;
        end
        ST_MEMRD: r_state <= ST_MEMWAIT;
        ST_MEMWAIT: begin
          r_mdata <= pmem_rdata;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_pc <= ev_pc_plus;
          r_sp <= ev_sp_min;
          if (ev_pmem_we) begin
            r_pmem_we    <= 1'b1;
            r_pmem_waddr <= ev_pmem_w_addr;
            r_pmem_wdata <= ev_pmem_out;
          end
          if (ev_stop) begin
            r_state <= ST_HALT;
          end else if (ev_sleep) begin
            r_cnt   <= SLEEP_LOAD;
            r_state <= ST_SLEEP;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_SLEEP: begin
          if (r_cnt == '0) r_state <= ST_FETCH;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_HALT: begin
          if (start) begin
            r_pc    <= START_PC;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign push_ready = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted     = (r_state == ST_HALT);
  assign pmem_we    = r_pmem_we;
  assign pmem_waddr = r_pmem_waddr;
  assign pmem_wdata = r_pmem_wdata;
  assign ev_opcode  = r_instr;
  assign ev_pc      = r_pc;
  assign ev_sp      = r_sp;
  assign ev_top     = w_top;
  assign ev_btop    = w_btop;
  assign ev_pmem_in = r_mdata;

endmodule

// File: tb/tb_oak_sequencer.sv
// Bench for oak_sequencer: behavioural evaluator and program memory around the
// DUT, directed scenarios plus random programs against an ISA-level model.
module tb_oak_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = '0;
  logic       push_ready;
  logic [5:0] pmem_raddr;
  logic [7:0] pmem_rdata;
  logic       pmem_we;
  logic [5:0] pmem_waddr;
  logic [7:0] pmem_wdata;
  logic [3:0] ev_opcode;
  logic [5:0] ev_pc;
  logic [3:0] ev_sp;
  logic [7:0] ev_top, ev_btop, ev_pmem_in;
  logic [5:0] ev_pc_plus;
  logic [3:0] ev_sp_min;
  logic [7:0] ev_sp_w_cnt, ev_new_top;
  logic       ev_pmem_we;
  logic [5:0] ev_pmem_w_addr;
  logic [7:0] ev_pmem_out;
  logic       ev_sleep, ev_stop;
  logic       busy, halted;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oak_sequencer #(.SLEEP_CYCLES(16), .START_PC(6'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .push_valid(push_valid),
    .push_data(push_data), .push_ready(push_ready), .pmem_raddr(pmem_raddr),
    .pmem_rdata(pmem_rdata), .pmem_we(pmem_we), .pmem_waddr(pmem_waddr),
    .pmem_wdata(pmem_wdata), .ev_opcode(ev_opcode), .ev_pc(ev_pc), .ev_sp(ev_sp),
    .ev_top(ev_top), .ev_btop(ev_btop), .ev_pmem_in(ev_pmem_in),
    .ev_pc_plus(ev_pc_plus), .ev_sp_min(ev_sp_min), .ev_sp_w_cnt(ev_sp_w_cnt),
    .ev_new_top(ev_new_top), .ev_pmem_we(ev_pmem_we), .ev_pmem_w_addr(ev_pmem_w_addr),
    .ev_pmem_out(ev_pmem_out), .ev_sleep(ev_sleep), .ev_stop(ev_stop),
    .busy(busy), .halted(halted)
  );

  // evaluator: binary ops pop into btop's slot, DUP pushes, STORE pops two
  always_comb begin
    ev_pc_plus     = ev_pc + 6'd1;
    ev_sp_min      = ev_sp;
    ev_sp_w_cnt    = 8'd0;
    ev_new_top     = 8'd0;
    ev_pmem_we     = 1'b0;
    ev_pmem_w_addr = 6'd0;
    ev_pmem_out    = 8'd0;
    ev_sleep       = 1'b0;
    ev_stop        = 1'b0;
    case (ev_opcode)
      4'h0: begin ev_sp_min = ev_sp - 4'd1; ev_sp_w_cnt = 8'd1; ev_new_top = ev_btop + ev_top; end
      4'h1: begin ev_sp_min = ev_sp - 4'd1; ev_sp_w_cnt = 8'd1; ev_new_top = ev_btop - ev_top; end
      4'h2: begin ev_sp_min = ev_sp - 4'd1; ev_sp_w_cnt = 8'd1; ev_new_top = ev_btop & ev_top; end
      4'h3: begin ev_sp_min = ev_sp - 4'd1; ev_sp_w_cnt = 8'd1; ev_new_top = ev_btop | ev_top; end
      4'h4: begin ev_sp_min = ev_sp - 4'd1; ev_sp_w_cnt = 8'd1; ev_new_top = ev_btop ^ ev_top; end
      4'h5: begin ev_sp_min = ev_sp + 4'd1; ev_sp_w_cnt = 8'd1; ev_new_top = ev_top; end
      4'h6: ev_sp_min = ev_sp - 4'd1;
      4'h7: begin
        ev_sp_min = ev_sp - 4'd2; ev_pmem_we = 1'b1;
        ev_pmem_w_addr = ev_top[5:0]; ev_pmem_out = ev_btop;
      end
      4'h8: begin ev_sp_w_cnt = 8'd1; ev_new_top = ev_pmem_in; end
      4'h9: begin ev_sp_w_cnt = 8'd1; ev_new_top = ev_btop; end
      4'hA: ev_sleep = 1'b1;
      4'hF: ev_stop = 1'b1;
      default: ;
    endcase
  end

  logic [7:0] mem [64];
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    pmem_rdata <= mem[pmem_raddr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (pmem_we) mem[pmem_waddr] <= pmem_wdata;
  end

  int         we_count = 0;
  int         we_long = 0;
  logic       prev_we = 1'b0;
  logic [5:0] last_waddr = '0;
  logic [7:0] last_wdata = '0;

  always @(negedge clk) begin
    if (pmem_we) begin
      we_count++;
      last_waddr = pmem_waddr;
      last_wdata = pmem_wdata;
      if (prev_we) we_long++;
    end
    prev_we = pmem_we;
  end

  task automatic do_reset();
    start = 1'b0; push_valid = 1'b0; ld_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_byte(input logic [5:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    push_valid = 1'b1; push_data = d;
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", push_ready); end
    n_checks++; if ({ev_pc, ev_sp, ev_top, ev_btop} !== 26'd0) begin n_fail++;
      $display("FAIL reset_arch got pc=%h sp=%h top=%h btop=%h want 0", ev_pc, ev_sp, ev_top, ev_btop); end
    n_checks++; if ({ev_opcode, ev_pmem_in, pmem_we, pmem_raddr} !== 19'd0) begin n_fail++;
      $display("FAIL reset_regs got op=%h min=%h we=%b ra=%h want 0", ev_opcode, ev_pmem_in, pmem_we, pmem_raddr); end
  endtask

  task automatic test_add();
    int cyc;
    do_reset();
    load_byte(6'd0, 8'h00); load_byte(6'd1, 8'h0F);
    push(8'd3); push(8'd5);
    pulse_start();
    run_to_halt(cyc);
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL add_cycles got %0d want 6", cyc); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL add_halted got %b want 1", halted); end
    n_checks++; if (ev_pc !== 6'd2) begin n_fail++; $display("FAIL add_pc got %h want 2", ev_pc); end
    n_checks++; if (ev_sp !== 4'd1) begin n_fail++; $display("FAIL add_sp got %h want 1", ev_sp); end
    n_checks++; if (ev_top !== 8'd8) begin n_fail++; $display("FAIL add_top got %h want 08", ev_top); end
    push(8'h66);
    n_checks++; if (ev_sp !== 4'd1) begin n_fail++; $display("FAIL halt_push_sp got %h want 1", ev_sp); end
  endtask

  task automatic test_store();
    int cyc, w0;
    do_reset();
    load_byte(6'd0, 8'h07); load_byte(6'd1, 8'h0F);
    push(8'hAA); push(8'h10);
    w0 = we_count;
    pulse_start();
    run_to_halt(cyc);
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL store_cycles got %0d want 6", cyc); end
    n_checks++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL store_we_count got %0d want 1", we_count - w0); end
    n_checks++; if (we_long !== 0) begin n_fail++; $display("FAIL store_we_width got %0d long pulses want 0", we_long); end
    n_checks++; if (last_waddr !== 6'h10) begin n_fail++; $display("FAIL store_waddr got %h want 10", last_waddr); end
    n_checks++; if (last_wdata !== 8'hAA) begin n_fail++; $display("FAIL store_wdata got %h want aa", last_wdata); end
    n_checks++; if (ev_sp !== 4'd0) begin n_fail++; $display("FAIL store_sp got %h want 0", ev_sp); end
    n_checks++; if (mem[16] !== 8'hAA) begin n_fail++; $display("FAIL store_mem got %h want aa", mem[16]); end
  endtask

  task automatic test_load();
    int cyc;
    do_reset();
    load_byte(6'h20, 8'h5C); load_byte(6'd0, 8'h38); load_byte(6'd1, 8'h0F);
    push(8'h20);
    pulse_start();
    run_to_halt(cyc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL load_cycles got %0d want 8", cyc); end
    n_checks++; if (ev_top !== 8'h5C) begin n_fail++; $display("FAIL load_top got %h want 5c", ev_top); end
    n_checks++; if (ev_sp !== 4'd1) begin n_fail++; $display("FAIL load_sp got %h want 1", ev_sp); end
  endtask

  task automatic test_sleep();
    int cyc;
    do_reset();
    load_byte(6'd0, 8'h0A); load_byte(6'd1, 8'h0F);
    push(8'h42);
    pulse_start();
    run_to_halt(cyc);
    // FETCH-to-FETCH across the sleep is 19, then 3 for STOP
    n_checks++; if (cyc !== 22) begin n_fail++; $display("FAIL sleep_cycles got %0d want 22", cyc); end
    n_checks++; if (ev_pc !== 6'd2) begin n_fail++; $display("FAIL sleep_pc got %h want 2", ev_pc); end
    // restart from HALT with a stray start mid-sleep that must be ignored
    pulse_start();
    cyc = 0;
    while (busy && cyc < 2000) begin
      start = (cyc == 8);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (cyc !== 22) begin n_fail++; $display("FAIL restart_cycles got %0d want 22", cyc); end
    n_checks++; if ({ev_sp, ev_top} !== {4'd1, 8'h42}) begin n_fail++;
      $display("FAIL restart_keep got sp=%h top=%h want sp=1 top=42", ev_sp, ev_top); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] b [17];
    do_reset();
    load_byte(6'd0, 8'h0F);
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    n_checks++; if (ev_sp !== 4'd1) begin n_fail++; $display("FAIL wrap_sp got %h want 1", ev_sp); end
    n_checks++; if (ev_top !== b[16]) begin n_fail++; $display("FAIL wrap_top got %h want %h", ev_top, b[16]); end
    n_checks++; if (ev_btop !== b[15]) begin n_fail++; $display("FAIL wrap_btop got %h want %h", ev_btop, b[15]); end
    start = 1'b1; push_valid = 1'b1; push_data = 8'h77;
    @(posedge clk); #1;
    start = 1'b0; push_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_push_busy got %b want 1", busy); end
    run_to_halt(cyc);
    n_checks++; if ({ev_sp, ev_top} !== {4'd1, b[16]}) begin n_fail++;
      $display("FAIL start_push_stack got sp=%h top=%h want sp=1 top=%h", ev_sp, ev_top, b[16]); end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_reset();
    load_byte(6'd0, 8'h08); load_byte(6'd5, 8'h99);
    push(8'h05);
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, halted, ev_pc, ev_sp, ev_top, ev_pmem_in} !== 28'd0) begin n_fail++;
      $display("FAIL memwait_reset got busy=%b pc=%h sp=%h top=%h min=%h want 0", busy, ev_pc, ev_sp, ev_top, ev_pmem_in); end
    do_reset();
    load_byte(6'd0, 8'h07);
    push(8'hAA); push(8'h10);
    w0 = we_count;
    pulse_start();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (we_count - w0 !== 0) begin n_fail++; $display("FAIL exec_reset_we got %0d pulses want 0", we_count - w0); end
    n_checks++; if ({busy, ev_pc, ev_sp, ev_top} !== 19'd0) begin n_fail++;
      $display("FAIL exec_reset_arch got busy=%b pc=%h sp=%h top=%h want 0", busy, ev_pc, ev_sp, ev_top); end
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int iters);
    logic [7:0] m_mem [64];
    logic [7:0] m_stk [16];
    logic [3:0] m_sp, bi;
    logic [5:0] m_pc;
    logic [7:0] top, btop, d;
    logic [3:0] op;
    logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                             4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    int n_ins, n_push, lat, cyc;
    bit done;
    for (int it = 0; it < iters; it++) begin
      do_reset();
      n_ins = $urandom_range(1, 12);
      for (int a = 0; a < 64; a++) begin
        d = 8'($urandom);
        if (a < n_ins) d[3:0] = ops[$urandom_range(0, 13)];
        else if (a == n_ins) d[3:0] = 4'hF;
        m_mem[a] = d;
        load_byte(6'(a), d);
      end
      for (int i = 0; i < 16; i++) m_stk[i] = 8'd0;
      m_sp = 4'd0;
      n_push = $urandom_range(0, 20);
      for (int i = 0; i < n_push; i++) begin
        d = 8'($urandom);
        m_sp = m_sp + 4'd1;
        m_stk[m_sp] = d;
        push(d);
      end
      m_pc = 6'd0; lat = 0; done = 1'b0;
      for (int g = 0; g < 64 && !done; g++) begin
        op = m_mem[m_pc][3:0];
        top = m_stk[m_sp];
        bi = m_sp - 4'd1;
        btop = m_stk[bi];
        lat += 3;
        case (op)
          4'h0: begin m_sp = bi; m_stk[m_sp] = btop + top; end
          4'h1: begin m_sp = bi; m_stk[m_sp] = btop - top; end
          4'h2: begin m_sp = bi; m_stk[m_sp] = btop & top; end
          4'h3: begin m_sp = bi; m_stk[m_sp] = btop | top; end
          4'h4: begin m_sp = bi; m_stk[m_sp] = btop ^ top; end
          4'h5: begin m_sp = m_sp + 4'd1; m_stk[m_sp] = top; end
          4'h6: m_sp = bi;
          4'h8: begin m_stk[m_sp] = m_mem[top[5:0]]; lat += 2; end
          4'h9: m_stk[m_sp] = btop;
          4'hA: lat += 16;
          4'hF: done = 1'b1;
          default: ;
        endcase
        m_pc = m_pc + 6'd1;
      end
      bi = m_sp - 4'd1;
      pulse_start();
      run_to_halt(cyc);
      n_checks++; if (cyc !== lat) begin n_fail++; $display("FAIL rand%0d_cycles got %0d want %0d", it, cyc, lat); end
      n_checks++; if ({halted, ev_pc, ev_sp} !== {1'b1, m_pc, m_sp}) begin n_fail++;
        $display("FAIL rand%0d_state got h=%b pc=%h sp=%h want h=1 pc=%h sp=%h", it, halted, ev_pc, ev_sp, m_pc, m_sp); end
      n_checks++; if ({ev_top, ev_btop} !== {m_stk[m_sp], m_stk[bi]}) begin n_fail++;
        $display("FAIL rand%0d_stack got top=%h btop=%h want top=%h btop=%h", it, ev_top, ev_btop, m_stk[m_sp], m_stk[bi]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_store();
    test_load();
    test_sleep();
    test_back_to_back();
    test_reset_mid();
    test_random(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
